// File: rtl/top_k_sampler_pkg.sv
// Types and constants shared by the top-k sampler and its address generator.
package top_k_sampler_pkg;

  localparam int BEAT_WIDTH = 256;
  localparam int LANE_WIDTH = 32;

  typedef enum logic [3:0] {
    IDLE,
    GEN,
    CHECK,
    WAIT_DATA,
    PLACE,
    DONE_WAIT,
    ORDER,
    HOLD,
    ABORT_DRAIN
  } state_t;

  // Smallest all-ones mask covering num_keys-1, so each draw lands in range with probability >= 1/2.
  function automatic logic [31:0] key_mask(input logic [31:0] num_keys);
    logic [31:0] m;
    m = num_keys - 32'd1;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

endpackage

// File: rtl/top_k_sampler_sample_addr_gen.sv
// Key-index generator: 32-bit maximal-length LFSR (x^32+x^22+x^2+x+1) masked to the key range.
module sample_addr_gen
  import top_k_sampler_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        step,
  input  logic [31:0] num_keys,
  output logic [31:0] addr
);

  logic [31:0] lfsr_reg;
  logic        feedback;

  assign feedback = lfsr_reg[31] ^ lfsr_reg[21] ^ lfsr_reg[1] ^ lfsr_reg[0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr_reg <= 32'd1;
    end else if (step) begin
      lfsr_reg <= {lfsr_reg[30:0], feedback};
    end
  end

  assign addr = lfsr_reg & key_mask(num_keys);

endmodule

// File: rtl/top_k_sampler.sv
// Random key sampler: draws key records from DDR, feeds their priorities to an external sorter,
// then hands off to the key-selection processors and waits for all enabled ones to finish.
module top_k_sampler
  import top_k_sampler_pkg::*;
#(
  parameter logic [63:0] DDR_BASE        = 64'd0,
  parameter int          ADDRESS_WIDTH   = 31,
  parameter int          KEY_STRIDE_LOG2 = 5,
  parameter int          PRI_LANE        = 2,
  parameter int          READ_LENGTH     = 32,
  parameter int          NUM_PROCS       = 8,
  parameter int          MAX_RETRY       = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start_update,
  input  logic                     abort,
  input  logic [31:0]              num_keys,
  input  logic [31:0]              max_n_values,
  input  logic [NUM_PROCS-1:0]     proc_mask,
  output logic                     control_fixed_location,
  output logic [ADDRESS_WIDTH-1:0] control_read_base,
  output logic [ADDRESS_WIDTH-1:0] control_read_length,
  output logic                     control_go,
  input  logic                     control_done,
  output logic                     user_read_buffer,
  input  logic                     user_data_available,
  input  logic [BEAT_WIDTH-1:0]    user_buffer_data,
  output logic                     sort_reset,
  output logic                     sort_en,
  output logic                     sort_place_en,
  output logic                     sort_wren,
  output logic                     sort_order,
  output logic [LANE_WIDTH-1:0]    sort_data,
  output logic                     start_key_process,
  input  logic [NUM_PROCS-1:0]     key_sel_done,
  output logic                     busy,
  output logic                     sample_error
);

  state_t               state_reg;
  logic [31:0]          sample_cnt_reg;
  logic [31:0]          retry_cnt_reg;
  logic [NUM_PROCS-1:0] finish_reg;
  logic                 done_seen_reg;
  logic                 beat_popped_reg;

  logic [31:0]          addr;
  logic                 addr_ok;
  logic                 lfsr_step;
  logic [31:0]          sample_target;
  logic [NUM_PROCS-1:0] finish_now;
  logic                 unused_beat;

  assign control_fixed_location = 1'b0;
  assign addr_ok       = addr < num_keys;
  assign sample_target = (max_n_values == 32'd0) ? 32'd1 : max_n_values;
  assign finish_now    = finish_reg | key_sel_done;
  assign unused_beat   = ^user_buffer_data;

  // A fresh draw is needed whenever the FSM heads into GEN.
  assign lfsr_step = !abort &&
                     ((state_reg == IDLE  && start_update) ||
                      (state_reg == CHECK && !addr_ok) ||
                      (state_reg == ORDER && sample_cnt_reg < sample_target && start_update));

  sample_addr_gen u_addr_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .step     (lfsr_step),
    .num_keys (num_keys),
    .addr     (addr)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg           <= IDLE;
      sample_cnt_reg      <= '0;
      retry_cnt_reg       <= '0;
      finish_reg          <= '0;
      done_seen_reg       <= 1'b0;
      beat_popped_reg     <= 1'b0;
      control_read_base   <= '0;
      control_read_length <= '0;
      control_go          <= 1'b0;
      user_read_buffer    <= 1'b0;
      sort_reset          <= 1'b0;
      sort_en             <= 1'b0;
      sort_place_en       <= 1'b0;
      sort_wren           <= 1'b0;
      sort_order          <= 1'b0;
      sort_data           <= '0;
      start_key_process   <= 1'b0;
      busy                <= 1'b0;
      sample_error        <= 1'b0;
    end else begin
      control_go        <= 1'b0;
      user_read_buffer  <= 1'b0;
      sort_reset        <= 1'b0;
      sort_place_en     <= 1'b0;
      sort_wren         <= 1'b0;
      sort_order        <= 1'b0;
      start_key_process <= 1'b0;
      finish_reg        <= finish_now;
      // control_done may pulse before DONE_WAIT is reached, so remember it.
      if (control_done) done_seen_reg <= 1'b1;

      if (abort && (state_reg inside {IDLE, GEN, CHECK, ORDER, HOLD})) begin
        state_reg  <= IDLE;
        busy       <= 1'b0;
        sort_reset <= 1'b1;
        sort_en    <= 1'b0;
        finish_reg <= '0;
      end else if (abort && (state_reg inside {WAIT_DATA, PLACE, DONE_WAIT})) begin
        state_reg <= ABORT_DRAIN;
      end else begin
        case (state_reg)
          IDLE: begin
            retry_cnt_reg <= '0;
            // A session left open by ORDER keeps its sample count.
            if (!sort_en) sample_cnt_reg <= '0;
            if (start_update) begin
              state_reg    <= GEN;
              busy         <= 1'b1;
              sort_en      <= 1'b1;
              sample_error <= 1'b0;
            end
          end
          GEN: state_reg <= CHECK;
          CHECK: begin
            if (addr_ok) begin
              control_read_base   <= ADDRESS_WIDTH'(DDR_BASE) +
                                     (ADDRESS_WIDTH'(addr) << KEY_STRIDE_LOG2);
              control_read_length <= ADDRESS_WIDTH'(READ_LENGTH);
              control_go          <= 1'b1;
              retry_cnt_reg       <= '0;
              done_seen_reg       <= 1'b0;
              beat_popped_reg     <= 1'b0;
              state_reg           <= WAIT_DATA;
            end else if (retry_cnt_reg == 32'(MAX_RETRY - 1)) begin
              sample_error  <= 1'b1;
              sort_reset    <= 1'b1;
              sort_en       <= 1'b0;
              retry_cnt_reg <= '0;
              busy          <= 1'b0;
              state_reg     <= IDLE;
            end else begin
              retry_cnt_reg <= retry_cnt_reg + 32'd1;
              state_reg     <= GEN;
            end
          end
          WAIT_DATA: begin
            if (user_data_available) begin
              sort_data      <= user_buffer_data[PRI_LANE*LANE_WIDTH +: LANE_WIDTH];
              sort_place_en  <= 1'b1;
              sample_cnt_reg <= sample_cnt_reg + 32'd1;
              state_reg      <= PLACE;
            end
          end
          PLACE: begin
            sort_wren        <= 1'b1;
            user_read_buffer <= 1'b1;
            beat_popped_reg  <= 1'b1;
            state_reg        <= DONE_WAIT;
          end
          DONE_WAIT: begin
            if (control_done || done_seen_reg) begin
              sort_order <= 1'b1;
              state_reg  <= ORDER;
            end
          end
          ORDER: begin
            if (sample_cnt_reg >= sample_target) begin
              start_key_process <= 1'b1;
              state_reg         <= HOLD;
            end else if (start_update) begin
              state_reg <= GEN;
            end else begin
              busy      <= 1'b0;
              state_reg <= IDLE;
            end
          end
          HOLD: begin
            if ((finish_now & proc_mask) == proc_mask) begin
              sort_reset <= 1'b1;
              sort_en    <= 1'b0;
              finish_reg <= '0;
              busy       <= 1'b0;
              state_reg  <= IDLE;
            end
          end
          ABORT_DRAIN: begin
            if (user_data_available && !beat_popped_reg) begin
              user_read_buffer <= 1'b1;
              beat_popped_reg  <= 1'b1;
            end
            if (control_done || done_seen_reg) begin
              sort_reset <= 1'b1;
              sort_en    <= 1'b0;
              busy       <= 1'b0;
              state_reg  <= IDLE;
            end
          end
          default: begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_top_k_sampler.sv
// Directed-plus-random bench for top_k_sampler with a one-beat DDR responder and pulse tallies.
module tb_top_k_sampler;

  localparam int NP = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start_update = 1'b0;
  logic          abort = 1'b0;
  logic [31:0]   num_keys = '0;
  logic [31:0]   max_n_values = '0;
  logic [NP-1:0] proc_mask = '0;
  logic [NP-1:0] key_sel_done = '0;
  logic          control_done = 1'b0;
  logic          user_data_available = 1'b0;
  logic [255:0]  user_buffer_data = '0;

  logic          control_fixed_location, control_go, user_read_buffer;
  logic [30:0]   control_read_base, control_read_length;
  logic          sort_reset, sort_en, sort_place_en, sort_wren, sort_order;
  logic [31:0]   sort_data;
  logic          start_key_process, busy, sample_error;

  logic          control_fixed_location_b, control_go_b, user_read_buffer_b;
  logic [30:0]   control_read_base_b, control_read_length_b;
  logic          sort_reset_b, sort_en_b, sort_place_en_b, sort_wren_b, sort_order_b;
  logic [31:0]   sort_data_b;
  logic          start_key_process_b, busy_b, sample_error_b;

  top_k_sampler dut (
    .clk(clk), .reset_n(reset_n), .start_update(start_update), .abort(abort),
    .num_keys(num_keys), .max_n_values(max_n_values), .proc_mask(proc_mask),
    .control_fixed_location(control_fixed_location), .control_read_base(control_read_base),
    .control_read_length(control_read_length), .control_go(control_go),
    .control_done(control_done), .user_read_buffer(user_read_buffer),
    .user_data_available(user_data_available), .user_buffer_data(user_buffer_data),
    .sort_reset(sort_reset), .sort_en(sort_en), .sort_place_en(sort_place_en),
    .sort_wren(sort_wren), .sort_order(sort_order), .sort_data(sort_data),
    .start_key_process(start_key_process), .key_sel_done(key_sel_done),
    .busy(busy), .sample_error(sample_error)
  );

  top_k_sampler #(.PRI_LANE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start_update(start_update), .abort(abort),
    .num_keys(num_keys), .max_n_values(max_n_values), .proc_mask(proc_mask),
    .control_fixed_location(control_fixed_location_b), .control_read_base(control_read_base_b),
    .control_read_length(control_read_length_b), .control_go(control_go_b),
    .control_done(control_done), .user_read_buffer(user_read_buffer_b),
    .user_data_available(user_data_available), .user_buffer_data(user_buffer_data),
    .sort_reset(sort_reset_b), .sort_en(sort_en_b), .sort_place_en(sort_place_en_b),
    .sort_wren(sort_wren_b), .sort_order(sort_order_b), .sort_data(sort_data_b),
    .start_key_process(start_key_process_b), .key_sel_done(key_sel_done),
    .busy(busy_b), .sample_error(sample_error_b)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int n_go, n_place, n_wren, n_order, n_skp, n_rb, n_sreset, busy_cycles;
  int last_order_cyc, skp_cyc;
  int data_timer = -1;
  int done_timer = -1;
  bit mem_auto = 1'b1;
  bit long_done = 1'b0;
  bit deadbeef_next = 1'b0;
  logic [31:0] exp_lane2, exp_lane0, first_pri;
  int exp_n;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return 128'({control_fixed_location, control_read_base, control_read_length, control_go,
                 user_read_buffer, sort_reset, sort_en, sort_place_en, sort_wren, sort_order,
                 sort_data, start_key_process, busy, sample_error});
  endfunction

  function automatic logic [127:0] outs_b();
    return 128'({control_fixed_location_b, control_read_base_b, control_read_length_b, control_go_b,
                 user_read_buffer_b, sort_reset_b, sort_en_b, sort_place_en_b, sort_wren_b,
                 sort_order_b, sort_data_b, start_key_process_b, busy_b, sample_error_b});
  endfunction

  task automatic clear_counts();
    n_go = 0; n_place = 0; n_wren = 0; n_order = 0; n_skp = 0; n_rb = 0; n_sreset = 0;
    busy_cycles = 0; last_order_cyc = -100; skp_cyc = -200;
  endtask

  // The priority field of a key record is the 32-bit lane PRI_LANE of its beat.
  task automatic present_beat();
    logic [31:0] lane;
    for (int i = 0; i < 8; i++) begin
      lane = $urandom;
      if (i == 2 && deadbeef_next) lane = 32'hDEADBEEF;
      user_buffer_data[i*32 +: 32] = lane;
      if (i == 2) exp_lane2 = lane;
      if (i == 0) exp_lane0 = lane;
    end
    deadbeef_next = 1'b0;
    user_data_available = 1'b1;
  endtask

  task automatic cyc();
    @(negedge clk);
    cycle++;
    if (busy) busy_cycles++;
    if (control_go) begin
      n_go++;
      check("base_align", 128'(control_read_base[4:0]), 128'(0));
      check("addr_in_range", 128'((32'(control_read_base) >> 5) < num_keys), 128'(1));
      check("read_length", 128'(control_read_length), 128'(32));
      if (mem_auto) begin
        data_timer = int'($urandom_range(1, 3));
        done_timer = long_done ? 25 : data_timer + int'($urandom_range(3, 5));
      end
    end
    if (sort_place_en) begin
      n_place++;
      if (n_place == 1) first_pri = sort_data;
      check("sort_data_lane2", 128'(sort_data), 128'(exp_lane2));
    end
    if (sort_place_en_b) check("sort_data_lane0", 128'(sort_data_b), 128'(exp_lane0));
    if (sort_wren) n_wren++;
    if (user_read_buffer) begin n_rb++; user_data_available = 1'b0; end
    if (sort_order) begin n_order++; last_order_cyc = cycle; end
    if (start_key_process) begin n_skp++; skp_cyc = cycle; end
    if (sort_reset) n_sreset++;
    control_done = 1'b0;
    if (data_timer > 0) begin
      data_timer--;
      if (data_timer == 0) begin present_beat(); data_timer = -1; end
    end
    if (done_timer > 0) begin
      done_timer--;
      if (done_timer == 0) begin control_done = 1'b1; done_timer = -1; end
    end
  endtask

  task automatic run_session(input int budget);
    start_update = 1'b1;
    for (int i = 0; i < budget && n_skp == 0; i++) cyc();
    start_update = 1'b0;
  endtask

  initial begin
    clear_counts();
    reset_n = 1'b0;
    repeat (3) cyc();
    check("rst_outputs", outs(), 128'(0));
    check("rst_outputs_lane0", outs_b(), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    reset_n = 1'b1;
    cyc();
    check("idle_busy", 128'(busy), 128'(0));
    check("idle_quiet", outs(), 128'(0));

    // Four samples from 256 keys, start held throughout.
    num_keys = 256; max_n_values = 4; proc_mask = 8'h05; deadbeef_next = 1'b1;
    clear_counts();
    run_session(400);
    check("t1_go", 128'(n_go), 128'(4));
    check("t1_place", 128'(n_place), 128'(4));
    check("t1_wren", 128'(n_wren), 128'(4));
    check("t1_order", 128'(n_order), 128'(4));
    check("t1_skp", 128'(n_skp), 128'(1));
    check("t1_skp_lag", 128'(skp_cyc - last_order_cyc), 128'(1));
    check("t1_deadbeef", 128'(first_pri), 128'(32'hDEADBEEF));
    cyc();
    check("t1_hold_busy", 128'(busy), 128'(1));
    check("t1_hold_sort_en", 128'(sort_en), 128'(1));

    // HOLD release needs bits 0 and 2; bit 1 alone is ignored.
    clear_counts();
    key_sel_done = 8'h02; cyc(); key_sel_done = '0;
    repeat (3) cyc();
    check("t2_bit1_hold", 128'(busy), 128'(1));
    key_sel_done = 8'h01; cyc(); key_sel_done = '0;
    repeat (9) cyc();
    check("t2_bit0_hold", 128'(busy), 128'(1));
    check("t2_no_sreset", 128'(n_sreset), 128'(0));
    key_sel_done = 8'h04; cyc(); key_sel_done = '0;
    check("t2_exit_busy", 128'(busy), 128'(0));
    check("t2_exit_sreset", 128'(sort_reset), 128'(1));
    check("t2_exit_sort_en", 128'(sort_en), 128'(0));
    cyc();

    // Random key counts and sample targets (0 means 1), immediate HOLD release.
    proc_mask = '0;
    for (int s = 0; s < 3; s++) begin
      num_keys = $urandom_range(1, 5000);
      max_n_values = $urandom_range(0, 3);
      exp_n = (max_n_values == 0) ? 1 : int'(max_n_values);
      clear_counts();
      run_session(800);
      check("t3_go", 128'(n_go), 128'(exp_n));
      check("t3_order", 128'(n_order), 128'(exp_n));
      check("t3_wren", 128'(n_wren), 128'(exp_n));
      check("t3_skp", 128'(n_skp), 128'(1));
      cyc();
      check("t3_exit_busy", 128'(busy), 128'(0));
      check("t3_exit_sreset", 128'(n_sreset), 128'(1));
      cyc();
    end

    // No valid keys: 64 rejected draws end in sample_error.
    num_keys = 0; max_n_values = 1;
    clear_counts();
    start_update = 1'b1; cyc(); start_update = 1'b0;
    for (int i = 0; i < 400 && busy; i++) cyc();
    check("t4_error", 128'(sample_error), 128'(1));
    check("t4_busy", 128'(busy), 128'(0));
    check("t4_no_go", 128'(n_go), 128'(0));
    check("t4_sreset", 128'(n_sreset), 128'(1));
    check("t4_busy_cycles", 128'(busy_cycles), 128'(128));
    cyc();

    // Abort while waiting for data: drain one beat, no sort strobes.
    mem_auto = 1'b0;
    num_keys = 256; max_n_values = 4;
    clear_counts();
    start_update = 1'b1;
    for (int i = 0; i < 300 && n_go == 0; i++) cyc();
    start_update = 1'b0;
    check("t5_error_cleared", 128'(sample_error), 128'(0));
    check("t5_go_seen", 128'(n_go), 128'(1));
    abort = 1'b1; cyc(); abort = 1'b0;
    check("t5_drain_busy", 128'(busy), 128'(1));
    cyc(); cyc();
    present_beat();
    cyc(); cyc();
    control_done = 1'b1;
    cyc();
    check("t5_idle_busy", 128'(busy), 128'(0));
    check("t5_sreset", 128'(sort_reset), 128'(1));
    check("t5_one_pop", 128'(n_rb), 128'(1));
    check("t5_no_wren", 128'(n_wren), 128'(0));
    check("t5_no_place", 128'(n_place), 128'(0));
    check("t5_no_order", 128'(n_order), 128'(0));
    mem_auto = 1'b1;
    cyc();

    // Reset in DONE_WAIT, then a clean session.
    long_done = 1'b1;
    num_keys = 256; max_n_values = 2;
    clear_counts();
    start_update = 1'b1;
    for (int i = 0; i < 300 && n_wren == 0; i++) cyc();
    check("t6_wren_seen", 128'(n_wren), 128'(1));
    reset_n = 1'b0; start_update = 1'b0;
    cyc();
    check("t6_rst_outputs", outs(), 128'(0));
    check("t6_rst_busy", 128'(busy), 128'(0));
    data_timer = -1; done_timer = -1; long_done = 1'b0;
    user_data_available = 1'b0; control_done = 1'b0;
    reset_n = 1'b1;
    cyc();
    check("t6_post_reset_quiet", outs(), 128'(0));
    num_keys = $urandom_range(1, 1000); max_n_values = 1;
    clear_counts();
    run_session(400);
    check("t6_go", 128'(n_go), 128'(1));
    check("t6_order", 128'(n_order), 128'(1));
    check("t6_skp", 128'(n_skp), 128'(1));
    cyc();
    check("t6_exit_busy", 128'(busy), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
